// File: rtl/nivel_cxa_sensor_pkg.sv
// Shared definitions for the tank-level path: level codes, FSM states, pattern encoder.
package nivel_cxa_sensor_pkg;

  localparam logic [1:0] NV_VAZIA = 2'b00;
  localparam logic [1:0] NV_BAIXO = 2'b01;
  localparam logic [1:0] NV_MEDIO = 2'b10;
  localparam logic [1:0] NV_CHEIA = 2'b11;

  typedef enum logic [1:0] {
    StValido   = 2'd0,
    StSuspeito = 2'd1,
    StErro     = 2'd2
  } estado_t;

  // Returns {consistent, level_code}; p = {baixo, medio, alto}.
  function automatic logic [2:0] codifica(input logic [2:0] p);
    logic [2:0] r;
    r = 3'b000;
    case (p)
      3'b000:  r = {1'b1, NV_VAZIA};
      3'b100:  r = {1'b1, NV_BAIXO};
      3'b110:  r = {1'b1, NV_MEDIO};
      3'b111:  r = {1'b1, NV_CHEIA};
      default: r = {1'b0, NV_VAZIA};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/debounce_sonda.sv
// Single probe front-end: 2-FF synchroniser followed by a stability counter.
module debounce_sonda
  import nivel_cxa_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise the raw probe, then accept a new value only after it is stable long enough.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CntMax) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/nivel_cxa_sensor.sv
// Tank-level front-end: debounced probes, consistency FSM, level code, change pulse, fault flag.
module nivel_cxa_sensor
  import nivel_cxa_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1000,
  parameter int unsigned ERR_CYCLES = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic S_BAIXO,
  input  logic S_MEDIO,
  input  logic S_ALTO,
  output logic Nv1,
  output logic Nv0,
  output logic NV_MUDOU,
  output logic ERRO
);

  localparam logic [CNT_W-1:0] EcntMax = CNT_W'(ERR_CYCLES);

  logic       w_deb_baixo;
  logic       w_deb_medio;
  logic       w_deb_alto;
  logic [2:0] w_cod;
  logic       w_valido;

  estado_t          r_estado;
  logic [CNT_W-1:0] r_ecnt;
  logic [1:0]       r_nv;
  logic [1:0]       r_nv_ant;
  logic             r_mudou;
  logic             r_erro;

  debounce_sonda #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_baixo (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_raw   (S_BAIXO),
    .o_deb   (w_deb_baixo)
  );

  debounce_sonda #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_medio (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_raw   (S_MEDIO),
    .o_deb   (w_deb_medio)
  );

  debounce_sonda #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_deb_alto (
    .i_clk   (CLK),
    .i_rst_n (RESET_N),
    .i_raw   (S_ALTO),
    .o_deb   (w_deb_alto)
  );

  assign w_cod    = codifica({w_deb_baixo, w_deb_medio, w_deb_alto});
  assign w_valido = w_cod[2];

  // Consistency FSM with shared error counter; level code only moves on a consistent pattern.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_estado <= StValido;
      r_ecnt   <= '0;
      r_nv     <= NV_VAZIA;
      r_nv_ant <= NV_VAZIA;
      r_mudou  <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      // Change pulse lags the code update by one edge so it lines up after the new value.
      r_nv_ant <= r_nv;
      r_mudou  <= (r_nv != r_nv_ant);
      unique case (r_estado)
        StValido: begin
          if (w_valido) begin
            r_nv <= w_cod[1:0];
          end else begin
            r_estado <= StSuspeito;
            r_ecnt   <= CNT_W'(1);
          end
        end
        StSuspeito: begin
          if (w_valido) begin
            r_estado <= StValido;
            r_nv     <= w_cod[1:0];
            r_ecnt   <= '0;
          end else if (r_ecnt == EcntMax) begin
            r_estado <= StErro;
            r_erro   <= 1'b1;
            r_ecnt   <= '0;
          end else begin
            r_ecnt <= r_ecnt + CNT_W'(1);
          end
        end
        StErro: begin
          if (w_valido) begin
            if (r_ecnt == EcntMax) begin
              r_estado <= StValido;
              r_erro   <= 1'b0;
              r_nv     <= w_cod[1:0];
              r_ecnt   <= '0;
            end else begin
              r_ecnt <= r_ecnt + CNT_W'(1);
            end
          end else begin
            r_ecnt <= '0;
          end
        end
        default: r_estado <= StValido;
      endcase
    end
  end

  assign Nv1      = r_nv[1];
  assign Nv0      = r_nv[0];
  assign NV_MUDOU = r_mudou;
  assign ERRO     = r_erro;

endmodule

// File: tb/tb_nivel_cxa_sensor.sv
// Bench for nivel_cxa_sensor with DEB_CYCLES = 4, ERR_CYCLES = 3.
module tb_nivel_cxa_sensor;

  logic CLK;
  logic RESET_N;
  logic S_BAIXO;
  logic S_MEDIO;
  logic S_ALTO;
  logic Nv1;
  logic Nv0;
  logic NV_MUDOU;
  logic ERRO;

  typedef struct {
    logic [2:0] probes;      // {baixo, medio, alto}
    int         hold;        // edges the probes are held
    logic [1:0] exp_nv;      // level code at end of hold
    logic       exp_erro;    // fault flag at end of hold
    int         exp_pulses;  // NV_MUDOU pulses seen during hold
    int         lat_nv;      // first edge showing exp_nv (0 = not checked)
    int         exp_erro_hi; // samples with ERRO high during hold
    string      name;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  int n_vec;
  int n_fail;

  nivel_cxa_sensor #(
    .DEB_CYCLES (4),
    .ERR_CYCLES (3),
    .CNT_W      (16)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .S_BAIXO  (S_BAIXO),
    .S_MEDIO  (S_MEDIO),
    .S_ALTO   (S_ALTO),
    .Nv1      (Nv1),
    .Nv0      (Nv0),
    .NV_MUDOU (NV_MUDOU),
    .ERRO     (ERRO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Drive a vector at a negedge, queue its expectations, observe hold edges, then score.
  task automatic apply_vec(input vec_t v);
    vec_t e;
    int   pulses;
    int   ehi;
    int   first;
    pulses = 0;
    ehi    = 0;
    first  = -1;
    {S_BAIXO, S_MEDIO, S_ALTO} = v.probes;
    sb.push_back(v);
    for (int k = 1; k <= v.hold; k++) begin
      step();
      if (NV_MUDOU) pulses++;
      if (ERRO) ehi++;
      if (first < 0 && {Nv1, Nv0} == v.exp_nv) first = k;
    end
    e = sb.pop_front();
    chk({e.name, "_nv"}, int'({Nv1, Nv0}), int'(e.exp_nv));
    chk({e.name, "_erro"}, int'(ERRO), int'(e.exp_erro));
    chk({e.name, "_pulses"}, pulses, e.exp_pulses);
    chk({e.name, "_erro_cycles"}, ehi, e.exp_erro_hi);
    if (e.lat_nv != 0) chk({e.name, "_nv_latency"}, first, e.lat_nv);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_nv"}, int'({Nv1, Nv0}), 0);
    chk({name, "_erro"}, int'(ERRO), 0);
    chk({name, "_mudou"}, int'(NV_MUDOU), 0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    vecs[0]  = '{3'b100, 20, 2'b01, 1'b0, 1, 7, 0, "fill_low"};
    vecs[1]  = '{3'b110, 20, 2'b10, 1'b0, 1, 7, 0, "fill_mid"};
    vecs[2]  = '{3'b111, 20, 2'b11, 1'b0, 1, 7, 0, "fill_full"};
    // Two probes fall together: one update, one pulse.
    vecs[3]  = '{3'b100, 20, 2'b01, 1'b0, 1, 7, 0, "double_drop"};
    // Mid probe glitch of 3 cycles is rejected.
    vecs[4]  = '{3'b110,  3, 2'b01, 1'b0, 0, 0, 0, "glitch_on"};
    vecs[5]  = '{3'b100, 20, 2'b01, 1'b0, 0, 0, 0, "glitch_off"};
    vecs[6]  = '{3'b110, 20, 2'b10, 1'b0, 1, 7, 0, "to_mid"};
    // Low drops, mid follows 2 cycles later: 010 seen for 2 edges, then 000 clears suspicion.
    vecs[7]  = '{3'b010,  2, 2'b10, 1'b0, 0, 0, 0, "transient_a"};
    vecs[8]  = '{3'b000, 20, 2'b00, 1'b0, 1, 7, 0, "transient_b"};
    vecs[9]  = '{3'b100, 20, 2'b01, 1'b0, 1, 7, 0, "to_low"};
    // Debounced 001 from edge 6; ERRO rises on edge 10 and Nv holds 01.
    vecs[10] = '{3'b001, 20, 2'b01, 1'b1, 0, 0, 11, "fault_set"};
    // Debounced 000 from edge 6; ERRO clears on edge 10 with Nv = 00.
    vecs[11] = '{3'b000, 20, 2'b00, 1'b0, 1, 10, 9, "fault_clear"};

    // Reset held 3 cycles with every probe wet.
    RESET_N = 1'b0;
    {S_BAIXO, S_MEDIO, S_ALTO} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("reset");
    end
    RESET_N = 1'b1;
    {S_BAIXO, S_MEDIO, S_ALTO} = 3'b000;
    step();
    chk_idle("release");

    for (int i = 0; i < 12; i++) apply_vec(vecs[i]);

    // Reset while the low probe is 2 counts into debounce; full latency applies after release.
    {S_BAIXO, S_MEDIO, S_ALTO} = 3'b100;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_nv", int'({Nv1, Nv0}), 0);
    RESET_N = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_idle("mid_reset");
    end
    RESET_N = 1'b1;
    apply_vec('{3'b100, 20, 2'b01, 1'b0, 1, 7, 0, "reset_restart"});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
